// File: rtl/click_count_ctrl.sv
// -----------------------------------------------------------------------------
// click_count_ctrl
//   Counts push-button clicks. Each raw active-low key is synchronized and
//   debounced. A debounced press (1->0) raises that key's pending request. A
//   two-state arbiter serves one request at a time through a shared 4-bit
//   ripple-carry adder. The result is committed into the count register, and
//   sticky wrap flags are kept alongside the count.
//
// Ports
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   inc_key_n  in   raw increment key, active-low, asynchronous to clk
//   dec_key_n  in   raw decrement key, active-low, asynchronous to clk
//   clr        in   synchronous clear, active-high
//   count      out  current click count (modulo 16)
//   overflow   out  sticky: an increment wrapped 15->0
//   underflow  out  sticky: a decrement wrapped 0->15
//   busy       out  high while the arbiter is in OP (mirrors the FSM state)
//   update     out  one-cycle pulse in the cycle after an operation commits
//
// Handshake: a pending flag is a request held until it is served. The arbiter
// accepts it in IDLE and retires it at the end of OP. No new request is
// accepted until the arbiter is back in IDLE.
// -----------------------------------------------------------------------------

// Plain 4-bit ripple-carry adder built from full-adder cells.
module fourbitadder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[4];
endmodule

module click_count_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc_key_n,
    input  logic       dec_key_n,
    input  logic       clr,
    output logic [3:0] count,
    output logic       overflow,
    output logic       underflow,
    output logic       busy,
    output logic       update
);
    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OP   = 1'b1
    } state_t;

    // Index 0 = increment key, index 1 = decrement key.
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  level_q, level_d;
    logic [19:0] cnt_q [2];
    logic [19:0] cnt_d [2];
    logic [1:0]  press;

    logic [1:0]  pend_q, pend_d;
    state_t      state_q, state_d;
    logic        op_inc_q, op_inc_d;
    logic        commit;

    logic [3:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        update_q, update_d;

    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        add_cout;

    // ---------------- debouncers ----------------
    always_comb begin
        level_d = level_q;
        press   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = 20'd0;
            if (sync2_q[k] != level_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    level_d[k] = ~level_q[k];
                    // Only a debounced fall (released -> pressed) is a click.
                    press[k]   = level_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 20'd1;
                end
            end
        end
    end

    // ---------------- arbiter FSM ----------------
    always_comb begin
        state_d  = state_q;
        op_inc_d = op_inc_q;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d  = S_OP;
                    op_inc_d = pend_q[0];   // increment wins ties
                end
            end
            S_OP: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
            commit  = 1'b0;
        end
    end

    // ---------------- shared adder ----------------
    // Decrement is count + 4'b1111; a missing carry-out means 0 wrapped to 15.
    assign add_b = op_inc_q ? 4'b0001 : 4'b1111;

    fourbitadder u_adder (
        .a_i    (count_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // ---------------- datapath next state ----------------
    always_comb begin
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        pend_d   = pend_q;
        update_d = commit;
        if (commit) begin
            count_d = add_sum;
            if (op_inc_q) begin
                pend_d[0] = 1'b0;
                if (add_cout) ovf_d = 1'b1;
            end else begin
                pend_d[1] = 1'b0;
                if (!add_cout) udf_d = 1'b1;
            end
        end
        // A new press may land on the edge its key is served; it stays pending.
        pend_d = pend_d | press;
        if (clr) begin
            count_d = 4'd0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            pend_d  = 2'b00;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            level_q  <= 2'b11;
            cnt_q[0] <= 20'd0;
            cnt_q[1] <= 20'd0;
            pend_q   <= 2'b00;
            state_q  <= S_IDLE;
            op_inc_q <= 1'b0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            sync1_q  <= {dec_key_n, inc_key_n};
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            pend_q   <= pend_d;
            state_q  <= state_d;
            op_inc_q <= op_inc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            update_q <= update_d;
        end
    end

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign busy      = (state_q == S_OP);
    assign update    = update_q;
endmodule

// File: doc/click_count_ctrl.md
# click_count_ctrl

Sequencing controller for the 4-bit ripple-carry adder `fourbitadder` that tracks push-button clicks. Two raw, active-low push buttons (increment and decrement) are synchronized and debounced, and each becomes a single press request. An arbiter shares one internal `fourbitadder` instance between the two requesters and commits the result into a 4-bit count register. Sticky wrap flags are kept alongside the count. The block sits between the board KEY inputs and the count display logic.

## Interface

- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level change is accepted (10 ms at 50 MHz). Legal range 2..2^20−1.

Ports:
- `clk`, in, 1: single system clock, rising-edge.
- `resetn`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `inc_key_n`, in, 1: raw increment button, active-low, asynchronous to `clk`.
- `dec_key_n`, in, 1: raw decrement button, active-low, asynchronous to `clk`.
- `clr`, in, 1: synchronous clear, active-high.
- `count`, out, 4: current click count.
- `overflow`, out, 1: sticky flag, set when an increment wraps 15→0.
- `underflow`, out, 1: sticky flag, set when a decrement wraps 0→15.
- `busy`, out, 1: high while the FSM is in OP.
- `update`, out, 1: one-cycle pulse in the cycle after `count` changes due to an operation.

## Operation

- **Per-key front end:** 2-flop synchronizer, then the debouncer.
  - The debouncer keeps a 20-bit counter. The counter increments while the synchronized level differs from the debounced level and resets to 0 otherwise.
  - When the counter equals `DEBOUNCE_CYCLES`−1 and the levels still differ, the debounced level flips and the counter resets.
  - A debounced 1→0 flip sets that key's pending flag on the same edge. Release (0→1) generates nothing.
- **Pending flags:** a press while the flag is already set is merged and dropped.
- **FSM states:**
  - IDLE: if any flag is pending, go to OP and latch the selected op. Increment has priority over decrement.
  - OP (one cycle): the adder is driven with a=`count`, b=4'b0001 (inc) or 4'b1111 (dec), cin=0. At the end of OP, `count`←sum and the served pending flag clears.
    - On inc with cout=1, set `overflow`.
    - On dec with cout=0, set `underflow`.
    - Return to IDLE.
- **Arithmetic:** modulo 16 wrap. Only the adder produces the next count; there is no separate incrementer.
- **Simultaneous requests:** the increment is served first. The decrement stays pending and is served in the next OP (IDLE→OP again).
- **`clr`:** takes effect on the edge it is sampled high and overrides a same-cycle OP commit. It zeroes `count`, `overflow`, `underflow` and both pending flags, returns the FSM to IDLE and suppresses `update`. Debouncer state is untouched.
- **Reset values:** `count`=0, `overflow`=0, `underflow`=0, `busy`=0, `update`=0, FSM=IDLE, pending=0, synchronizers=1, debounced levels=1 (released), debounce counters=0.
- **Reset mid-operation:** assertion clears everything immediately, so an in-flight OP is lost. A key held low across reset release produces exactly one press after debounce.

## Timing

- The raw key is first sampled low at edge 1. The synchronizer output goes low at edge 2. The debounced level flips and pending sets at edge 2+`DEBOUNCE_CYCLES`. OP is entered at edge 3+`DEBOUNCE_CYCLES`. `count` updates at edge 4+`DEBOUNCE_CYCLES`. `update` is high for the following cycle.
- `busy` is high for exactly one cycle per operation.
- Maximum commit rate is one operation per 2 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no press.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- **Single increment:** reset, hold `inc_key_n` low for 20 cycles → `count` goes 0→1 exactly 8 edges after the first low sample, `update` pulses once, and there is no second increment on release.
- **Glitch rejection:** drive `inc_key_n` low for 3 cycles, then high → `count` stays 0, `busy` never rises.
- **Overflow:** 16 debounced increments → `count` reads 15 before the 16th and 0 after it, and `overflow`=1 thereafter. Then 1 decrement from 0 → `count`=15, `underflow`=1.
- **Simultaneous press:** from `count`=5, press both keys on the same cycle → `count` reads 6, then returns to 5 two cycles later, with two `busy` pulses.
- **Clear collision:** assert `clr` in the same cycle as OP from `count`=9 → `count`=0, no `update`, flags 0, FSM in IDLE.
- **Reset mid-op:** assert `resetn` low during OP from `count`=3 → all outputs go 0 immediately. Release with the key held low → one increment to 1 after 8 edges.
